// File: rtl/pwm_duty_sched.sv
// pwm_duty_sched: slews the applied PWM duty toward a requested target,
// at most STEP counts per 2048-cycle frame, with soft-stop and brake cut-off.
module pwm_duty_sched #(
    parameter int STEP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        brake,
    input  logic        tgt_vld,
    input  logic [10:0] tgt_duty,
    output logic        tgt_rdy,
    output logic [10:0] duty,
    output logic        period_end,
    output logic        settled
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] HOLD     = 3'd1;
    localparam logic [2:0] RAMP     = 3'd2;
    localparam logic [2:0] SOFTSTOP = 3'd3;
    localparam logic [2:0] BRAKE    = 3'd4;

    localparam logic [11:0] STEP_W = 12'(STEP);
    localparam logic [10:0] STEP_N = 11'(STEP);

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic [10:0] cnt;
    logic [10:0] tgt;
    logic [10:0] tgt_nx;
    logic [10:0] duty_nx;
    logic [11:0] up_gap;
    logic [11:0] dn_gap;
    logic [10:0] up_sum;
    logic [10:0] dn_sum;
    logic [10:0] toward;
    logic [10:0] stop_val;
    logic        accept;

    // period_end is registered one count early so it is glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt + 11'd1;
            period_end <= (cnt == 11'd2046);
        end
    end

    assign up_gap = {1'b0, tgt} - {1'b0, duty};
    assign dn_gap = {1'b0, duty} - {1'b0, tgt};
    assign up_sum = duty + STEP_N;
    assign dn_sum = duty - STEP_N;

    always_comb begin
        toward = duty;
        if (tgt > duty) begin
            toward = (up_gap <= STEP_W) ? tgt : up_sum;
        end else if (tgt < duty) begin
            toward = (dn_gap <= STEP_W) ? tgt : dn_sum;
        end
    end

    assign stop_val = ({1'b0, duty} > STEP_W) ? dn_sum : 11'd0;

    assign tgt_rdy = en & ~brake & ((state == HOLD) | (state == RAMP));
    assign accept  = tgt_vld & tgt_rdy;
    assign settled = (state == IDLE) | (state == HOLD);

    always_comb begin
        state_nx = state;
        duty_nx  = duty;
        tgt_nx   = tgt;
        if (brake) begin
            state_nx = BRAKE;
            duty_nx  = '0;
            tgt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    duty_nx = '0;
                    if (en) state_nx = HOLD;
                end
                HOLD: begin
                    if (!en) begin
                        state_nx = (duty == 11'd0) ? IDLE : SOFTSTOP;
                    end else if (accept) begin
                        tgt_nx   = tgt_duty;
                        state_nx = (tgt_duty == duty) ? HOLD : RAMP;
                    end
                end
                RAMP: begin
                    if (!en) begin
                        state_nx = SOFTSTOP;
                    end else begin
                        // step uses the old target; a new one applies next frame
                        if (period_end) duty_nx = toward;
                        if (accept) tgt_nx = tgt_duty;
                        state_nx = (duty_nx == tgt_nx) ? HOLD : RAMP;
                    end
                end
                SOFTSTOP: begin
                    if (period_end) begin
                        duty_nx = stop_val;
                        if (stop_val == 11'd0) state_nx = IDLE;
                    end
                end
                BRAKE: begin
                    duty_nx  = '0;
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                    duty_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            duty  <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nx;
            duty  <= duty_nx;
            tgt   <= tgt_nx;
        end
    end

endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: directed frame sequences plus random traffic,
// every cycle compared against a behavioural model of the scheduler.
module tb_pwm_duty_sched;

    localparam int S0 = 16;
    localparam int S1 = 1024;
    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_RAMP = 2;
    localparam int M_SOFT = 3;
    localparam int M_BRK  = 4;

    typedef struct packed {
        int mode;
        int duty;
        int tgt;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en [2];
    logic        brake [2];
    logic        vld [2];
    logic [10:0] td [2];
    logic        rdy [2];
    logic [10:0] duty [2];
    logic        pe [2];
    logic        settled [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    mst_t m [2];
    bit   chk_on = 1'b0;
    bit   done0 = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_sched #(.STEP(S0)) u0 (
        .clk(clk), .rst(rst), .en(en[0]), .brake(brake[0]),
        .tgt_vld(vld[0]), .tgt_duty(td[0]), .tgt_rdy(rdy[0]),
        .duty(duty[0]), .period_end(pe[0]), .settled(settled[0])
    );

    pwm_duty_sched #(.STEP(S1)) u1 (
        .clk(clk), .rst(rst), .en(en[1]), .brake(brake[1]),
        .tgt_vld(vld[1]), .tgt_duty(td[1]), .tgt_rdy(rdy[1]),
        .duty(duty[1]), .period_end(pe[1]), .settled(settled[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int approach(int d, int t, int s);
        if (t > d) return (d + s < t) ? d + s : t;
        return (d - s > t) ? d - s : t;
    endfunction

    function automatic mst_t ref_next(mst_t s, int step, bit fend,
                                      bit e, bit b, bit v, int t);
        mst_t n;
        bit take;
        n = s;
        take = v && e && !b && (s.mode == M_HOLD || s.mode == M_RAMP);
        if (b) begin
            n.mode = M_BRK;
            n.duty = 0;
            n.tgt  = 0;
            return n;
        end
        case (s.mode)
            M_IDLE: if (e) n.mode = M_HOLD;
            M_BRK:  n.mode = M_IDLE;
            M_SOFT: begin
                if (fend) begin
                    n.duty = (s.duty > step) ? s.duty - step : 0;
                    if (n.duty == 0) n.mode = M_IDLE;
                end
            end
            M_HOLD: begin
                if (!e) n.mode = (s.duty == 0) ? M_IDLE : M_SOFT;
                else if (take) begin
                    n.tgt  = t;
                    n.mode = (t == s.duty) ? M_HOLD : M_RAMP;
                end
            end
            default: begin
                if (!e) n.mode = M_SOFT;
                else begin
                    if (fend) n.duty = approach(s.duty, s.tgt, step);
                    if (take) n.tgt = t;
                    n.mode = (n.duty == n.tgt) ? M_HOLD : M_RAMP;
                end
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < 2; i++) m[i] <= '{mode: M_IDLE, duty: 0, tgt: 0};
        end else begin
            cyc  <= cyc + 1;
            m[0] <= ref_next(m[0], S0, (cyc % 2048) == 2047,
                             en[0], brake[0], vld[0], int'(td[0]));
            m[1] <= ref_next(m[1], S1, (cyc % 2048) == 2047,
                             en[1], brake[1], vld[1], int'(td[1]));
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("duty%0d", i), int'(duty[i]), m[i].duty);
                check($sformatf("settled%0d", i), int'(settled[i]),
                      int'(m[i].mode == M_IDLE || m[i].mode == M_HOLD));
                check($sformatf("period_end%0d", i), int'(pe[i]),
                      int'((cyc % 2048) == 2047));
                check($sformatf("tgt_rdy%0d", i), int'(rdy[i]),
                      int'(en[i] && !brake[i] &&
                           (m[i].mode == M_HOLD || m[i].mode == M_RAMP)));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic at_fc(input int f);
        int n = 0;
        while ((cyc % 2048) != f && n < 2049) begin
            tick();
            n++;
        end
    endtask

    task automatic next_frame();
        tick();
        at_fc(0);
    endtask

    task automatic send(input int i, input int v);
        int n = 0;
        vld[i] = 1'b1;
        td[i]  = 11'(v);
        #1;
        while (!rdy[i] && n < 8192) begin
            tick();
            n++;
        end
        check("send_timeout", int'(n < 8192), 1);
        tick();
        vld[i] = 1'b0;
    endtask

    task automatic expect_frames(input int i, input int seq [$], input string tag);
        foreach (seq[k]) begin
            next_frame();
            check($sformatf("%s[%0d]", tag, k), int'(duty[i]), seq[k]);
        end
    endtask

    function automatic int pick_duty();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return 2047;
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic run_u0();
        en[0] = 1'b1;
        tick();
        tick();
        send(0, 100);
        expect_frames(0, '{16, 32, 48, 64, 80, 96, 100}, "up100");
        check("settled_at_100", int'(settled[0]), 1);
        at_fc(1000);
        check("hold_midframe", int'(duty[0]), 100);

        send(0, 40);
        expect_frames(0, '{84, 68, 52, 40}, "down40");
        check("settled_at_40", int'(settled[0]), 1);

        send(0, 50);
        expect_frames(0, '{50}, "to50");
        en[0] = 1'b0;
        tick();
        check("softstop_unsettled", int'(settled[0]), 0);
        expect_frames(0, '{34}, "soft");
        at_fc(100);
        en[0] = 1'b1;
        #1;
        check("soft_rdy_low", int'(rdy[0]), 0);
        repeat (3) tick();
        en[0] = 1'b0;
        expect_frames(0, '{18, 2, 0}, "soft");
        check("soft_idle", int'(settled[0]), 1);

        en[0] = 1'b1;
        tick();
        tick();
        send(0, 200);
        expect_frames(0, '{16, 32, 48}, "to200");
        at_fc(2047);
        send(0, 120);
        check("pe_accept_old_tgt", int'(duty[0]), 64);
        expect_frames(0, '{80, 96, 112, 120}, "to120");

        send(0, 400);
        expect_frames(0, '{136}, "to400");
        at_fc(1000);
        brake[0] = 1'b1;
        #1;
        check("brake_rdy", int'(rdy[0]), 0);
        tick();
        check("brake_duty", int'(duty[0]), 0);
        brake[0] = 1'b0;
        tick();
        tick();
        check("post_brake_duty", int'(duty[0]), 0);
        check("post_brake_settled", int'(settled[0]), 1);
        done0 = 1'b1;
    endtask

    task automatic run_u1();
        en[1] = 1'b1;
        tick();
        tick();
        send(1, 2040);
        expect_frames(1, '{1024, 2040}, "big2040");
        send(1, 2047);
        expect_frames(1, '{2047}, "top2047");
        check("top_settled", int'(settled[1]), 1);
        send(1, 5);
        expect_frames(1, '{1023, 5}, "down5");
        send(1, 0);
        expect_frames(1, '{0}, "zero");
        while (!done0) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 45) begin
                en[1] = 1'b1;
                send(1, pick_duty());
            end else if (r < 55) begin
                en[1] = 1'b0;
                repeat ($urandom_range(1, 3000)) tick();
                en[1] = 1'b1;
            end else if (r < 62) begin
                brake[1] = 1'b1;
                repeat ($urandom_range(1, 4)) tick();
                brake[1] = 1'b0;
            end else if (r < 80) begin
                en[1] = 1'b1;
                at_fc(2047);
                send(1, pick_duty());
            end else begin
                repeat ($urandom_range(1, 3000)) tick();
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i]    = 1'b0;
            brake[i] = 1'b0;
            vld[i]   = 1'b0;
            td[i]    = '0;
        end
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_duty", int'(duty[0]), 0);
        check("reset_settled", int'(settled[0]), 1);
        check("reset_rdy", int'(rdy[0]), 0);
        check("reset_pe", int'(pe[0]), 0);
        chk_on = 1'b1;
        #2;
        rst = 1'b0;

        fork
            run_u0();
            run_u1();
        join

        en[0]    = 1'b1;
        en[1]    = 1'b1;
        brake[1] = 1'b0;
        tick();
        send(1, 1500);
        send(0, 1000);
        expect_frames(0, '{16}, "pre_reset");
        at_fc(500);
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_duty%0d", i), int'(duty[i]), 0);
            check($sformatf("arst_settled%0d", i), int'(settled[i]), 1);
            check($sformatf("arst_rdy%0d", i), int'(rdy[i]), 0);
            check($sformatf("arst_pe%0d", i), int'(pe[i]), 0);
        end
        tick();
        rst = 1'b0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
